instr_fetch: RTL and testbench

//  Fetch stage between the program counter and decode. Drives rom_addr into the

---
 rtl/instr_fetch.sv | 107 ++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: drives the ROM address from pc and registers the returned word into ir.
// Latency: one cycle from pc to ir. Completes the fetch on the same edge.
// Backpressure: ir, ir_pc and pc hold while ir_valid=1 and ir_ready=0. jump_en flushes ir.
module instr_fetch #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16,
    parameter bit WRAP   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   fetch;
    logic   last_fetch;

    // The ROM is combinational, so the word for pc is available this cycle.
    assign rom_addr = pc;

    // A fetch needs RUN and a free (or draining) ir. A jump always suppresses it.
    assign fetch = (state == RUN) && (!ir_valid || ir_ready) && !jump_en;

    // Without wrap, fetching the top address ends the program.
    assign last_fetch = fetch && !WRAP && (pc == LAST_ADDR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. halt_req beats start when both arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !halt_req) state_nxt = RUN;
            RUN:     if (halt_req || last_fetch) state_nxt = HALT;
            HALT:    if (start && !halt_req) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the state.
    always_comb begin
        running = (state == RUN);
    end

    // Datapath. Priority: jump flush, then fetch, then a consume with no refill.
    // After the last fetch without wrap, pc stays on the last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (jump_en) begin
            pc       <= jump_addr;
            ir_valid <= 1'b0;
        end else if (fetch) begin
            ir       <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (!last_fetch) begin
                pc <= pc + ADDR_W'(1);
            end
        end else if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
        end
    end

    // done is set by the last fetch and cleared by the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (last_fetch) begin
            done <= 1'b1;
        end else if (start) begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. It covers two instances: wrap (u_wrap) and stop at the end (u_stop).
// Both instances share their control inputs and the ROM contents. Each one has its own ROM read port.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        jump_en;
    logic [3:0]  jump_addr;
    logic        ir_ready;

    logic [3:0]  rom_addr0, rom_addr1;
    logic [15:0] rom_data0, rom_data1;
    logic [15:0] ir0, ir1;
    logic [3:0]  ir_pc0, ir_pc1, pc0, pc1;
    logic        ir_valid0, ir_valid1, running0, running1, done0, done1;

    logic [15:0] rom [16];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign rom_data0 = rom[rom_addr0];
    assign rom_data1 = rom[rom_addr1];

    instr_fetch #(.ADDR_W(4), .INST_W(16), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .jump_en(jump_en), .jump_addr(jump_addr), .rom_addr(rom_addr0),
        .rom_data(rom_data0), .ir(ir0), .ir_pc(ir_pc0), .ir_valid(ir_valid0),
        .ir_ready(ir_ready), .pc(pc0), .running(running0), .done(done0)
    );

    instr_fetch #(.ADDR_W(4), .INST_W(16), .WRAP(1'b0)) u_stop (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .jump_en(jump_en), .jump_addr(jump_addr), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .ir(ir1), .ir_pc(ir_pc1), .ir_valid(ir_valid1),
        .ir_ready(ir_ready), .pc(pc1), .running(running1), .done(done1)
    );

    // One rising edge, then settle at the falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset both instances, then pulse start. Afterwards both are in RUN with pc=0.
    task automatic reset_and_start();
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; jump_en = 1'b0;
        jump_addr = 4'd0; ir_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; jump_en = 1'b0;
        jump_addr = 4'd0; ir_ready = 1'b1;
        #1;
        n_chk++; if (pc0 !== 4'd0) $display("FAIL reset_pc got %0d want 0", pc0); else n_pass++;
        n_chk++; if (ir0 !== 16'h0000) $display("FAIL reset_ir got %h want 0000", ir0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd0) $display("FAIL reset_ir_pc got %0d want 0", ir_pc0); else n_pass++;
        n_chk++; if (ir_valid0 !== 1'b0) $display("FAIL reset_ir_valid got %b want 0", ir_valid0); else n_pass++;
        n_chk++; if (done0 !== 1'b0) $display("FAIL reset_done got %b want 0", done0); else n_pass++;
        n_chk++; if (running0 !== 1'b0) $display("FAIL reset_running got %b want 0", running0); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        n_chk++; if (running0 !== 1'b0) $display("FAIL idle_running got %b want 0", running0); else n_pass++;
        n_chk++; if (pc0 !== 4'd0) $display("FAIL idle_pc got %0d want 0", pc0); else n_pass++;
        n_chk++; if (ir_valid0 !== 1'b0) $display("FAIL idle_ir_valid got %b want 0", ir_valid0); else n_pass++;
    endtask

    task automatic test_fetch();
        reset_and_start();
        n_chk++; if (running0 !== 1'b1) $display("FAIL start_running got %b want 1", running0); else n_pass++;
        n_chk++; if (ir_valid0 !== 1'b0) $display("FAIL start_ir_valid got %b want 0", ir_valid0); else n_pass++;
        tick();
        n_chk++; if (ir0 !== 16'h1209) $display("FAIL fetch0_ir got %h want 1209", ir0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd0) $display("FAIL fetch0_ir_pc got %0d want 0", ir_pc0); else n_pass++;
        n_chk++; if (pc0 !== 4'd1) $display("FAIL fetch0_pc got %0d want 1", pc0); else n_pass++;
        n_chk++; if (ir_valid0 !== 1'b1) $display("FAIL fetch0_ir_valid got %b want 1", ir_valid0); else n_pass++;
        tick();
        n_chk++; if (ir0 !== 16'h1407) $display("FAIL fetch1_ir got %h want 1407", ir0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd1) $display("FAIL fetch1_ir_pc got %0d want 1", ir_pc0); else n_pass++;
        n_chk++; if (pc0 !== 4'd2) $display("FAIL fetch1_pc got %0d want 2", pc0); else n_pass++;
    endtask

    // Continues from test_fetch with pc=2.
    task automatic test_stall();
        tick();
        n_chk++; if (ir0 !== 16'h200F) $display("FAIL stall_pre_ir got %h want 200f", ir0); else n_pass++;
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (ir0 !== 16'h200F) $display("FAIL stall_ir cyc %0d got %h want 200f", i, ir0); else n_pass++;
            n_chk++; if (ir_pc0 !== 4'd2) $display("FAIL stall_ir_pc cyc %0d got %0d want 2", i, ir_pc0); else n_pass++;
            n_chk++; if (pc0 !== 4'd3) $display("FAIL stall_pc cyc %0d got %0d want 3", i, pc0); else n_pass++;
            n_chk++; if (ir_valid0 !== 1'b1) $display("FAIL stall_ir_valid cyc %0d got %b want 1", i, ir_valid0); else n_pass++;
        end
        ir_ready = 1'b1;
        tick();
        n_chk++; if (ir0 !== 16'hA003) $display("FAIL release_ir got %h want a003", ir0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd3) $display("FAIL release_ir_pc got %0d want 3", ir_pc0); else n_pass++;
        n_chk++; if (pc0 !== 4'd4) $display("FAIL release_pc got %0d want 4", pc0); else n_pass++;
    endtask

    task automatic test_jump();
        reset_and_start();
        repeat (3) tick();
        n_chk++; if (pc0 !== 4'd3) $display("FAIL jump_pre_pc got %0d want 3", pc0); else n_pass++;
        jump_en = 1'b1; jump_addr = 4'd8;
        tick();
        jump_en = 1'b0;
        n_chk++; if (ir_valid0 !== 1'b0) $display("FAIL jump_flush got %b want 0", ir_valid0); else n_pass++;
        n_chk++; if (pc0 !== 4'd8) $display("FAIL jump_pc got %0d want 8", pc0); else n_pass++;
        tick();
        n_chk++; if (ir0 !== 16'h3C00) $display("FAIL jump_ir got %h want 3c00", ir0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd8) $display("FAIL jump_ir_pc got %0d want 8", ir_pc0); else n_pass++;
        n_chk++; if (pc0 !== 4'd9) $display("FAIL jump_next_pc got %0d want 9", pc0); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_pc [3];
        exp_pc[0] = 4'd15; exp_pc[1] = 4'd0; exp_pc[2] = 4'd1;
        reset_and_start();
        repeat (15) tick();
        n_chk++; if (ir_pc0 !== 4'd14) $display("FAIL wrap_pre_ir_pc got %0d want 14", ir_pc0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (ir_pc0 !== exp_pc[i]) $display("FAIL wrap_ir_pc step %0d got %0d want %0d", i, ir_pc0, exp_pc[i]); else n_pass++;
            n_chk++; if (done0 !== 1'b0) $display("FAIL wrap_done step %0d got %b want 0", i, done0); else n_pass++;
            if (i == 1) begin
                n_chk++; if (ir_pc1 !== 4'd15) $display("FAIL stop_ir_pc got %0d want 15", ir_pc1); else n_pass++;
                n_chk++; if (done1 !== 1'b1) $display("FAIL stop_done_set got %b want 1", done1); else n_pass++;
            end
        end
        n_chk++; if (running1 !== 1'b0) $display("FAIL stop_running got %b want 0", running1); else n_pass++;
        n_chk++; if (done1 !== 1'b1) $display("FAIL stop_done_hold got %b want 1", done1); else n_pass++;
        n_chk++; if (pc1 !== 4'd15) $display("FAIL stop_pc got %0d want 15", pc1); else n_pass++;
        n_chk++; if (ir1 !== 16'hA00F) $display("FAIL stop_ir got %h want a00f", ir1); else n_pass++;
        n_chk++; if (ir_valid1 !== 1'b0) $display("FAIL stop_consumed got %b want 0", ir_valid1); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++; if (done1 !== 1'b0) $display("FAIL stop_done_clear got %b want 0", done1); else n_pass++;
        n_chk++; if (running1 !== 1'b1) $display("FAIL stop_restart got %b want 1", running1); else n_pass++;
    endtask

    task automatic test_halt();
        reset_and_start();
        repeat (5) tick();
        n_chk++; if (pc0 !== 4'd5) $display("FAIL halt_pre_pc got %0d want 5", pc0); else n_pass++;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_chk++; if (ir_pc0 !== 4'd5) $display("FAIL halt_last_ir_pc got %0d want 5", ir_pc0); else n_pass++;
        n_chk++; if (ir0 !== 16'hA005) $display("FAIL halt_last_ir got %h want a005", ir0); else n_pass++;
        n_chk++; if (running0 !== 1'b0) $display("FAIL halt_running got %b want 0", running0); else n_pass++;
        tick(); tick();
        n_chk++; if (pc0 !== 4'd6) $display("FAIL halt_pc_hold got %0d want 6", pc0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd5) $display("FAIL halt_ir_pc_hold got %0d want 5", ir_pc0); else n_pass++;
        n_chk++; if (ir_valid0 !== 1'b0) $display("FAIL halt_consumed got %b want 0", ir_valid0); else n_pass++;
        start = 1'b1; halt_req = 1'b1;
        tick();
        start = 1'b0; halt_req = 1'b0;
        n_chk++; if (running0 !== 1'b0) $display("FAIL halt_wins got %b want 0", running0); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++; if (running0 !== 1'b1) $display("FAIL resume_running got %b want 1", running0); else n_pass++;
        n_chk++; if (pc0 !== 4'd6) $display("FAIL resume_pc got %0d want 6", pc0); else n_pass++;
        tick();
        n_chk++; if (ir0 !== 16'hF200) $display("FAIL resume_ir got %h want f200", ir0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd6) $display("FAIL resume_ir_pc got %0d want 6", ir_pc0); else n_pass++;
        n_chk++; if (pc0 !== 4'd7) $display("FAIL resume_pc_next got %0d want 7", pc0); else n_pass++;
    endtask

    task automatic test_async_reset();
        reset_and_start();
        repeat (3) tick();
        n_chk++; if (ir_valid0 !== 1'b1) $display("FAIL arst_pre_valid got %b want 1", ir_valid0); else n_pass++;
        ir_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (ir_valid0 !== 1'b0) $display("FAIL arst_ir_valid got %b want 0", ir_valid0); else n_pass++;
        n_chk++; if (pc0 !== 4'd0) $display("FAIL arst_pc got %0d want 0", pc0); else n_pass++;
        n_chk++; if (ir0 !== 16'h0000) $display("FAIL arst_ir got %h want 0000", ir0); else n_pass++;
        n_chk++; if (ir_pc0 !== 4'd0) $display("FAIL arst_ir_pc got %0d want 0", ir_pc0); else n_pass++;
        n_chk++; if (running0 !== 1'b0) $display("FAIL arst_running got %b want 0", running0); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'hA000 | 16'(i);
        rom[0] = 16'h1209; rom[1] = 16'h1407; rom[2] = 16'h200F;
        rom[6] = 16'hF200; rom[8] = 16'h3C00;

        test_reset();
        test_fetch();
        test_stall();
        test_jump();
        test_wrap();
        test_halt();
        test_async_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
